// File: rtl/shift_reg_univ.sv
// Universal shift register: hold / shift up / shift down / parallel load,
// with optional rotate and a burst controller for N back-to-back shifts.
module shift_reg_univ #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   en,
    input  logic [1:0]             mode,
    input  logic                   rot,
    input  logic [WIDTH-1:0]       sin_lo,
    input  logic [WIDTH-1:0]       sin_hi,
    input  logic [DEPTH*WIDTH-1:0] pin,
    input  logic                   start,
    input  logic                   burst_dir,
    input  logic [CNT_W-1:0]       burst_len,
    output logic [DEPTH*WIDTH-1:0] pout,
    output logic [WIDTH-1:0]       sout_hi,
    output logic [WIDTH-1:0]       sout_lo,
    output logic                   busy,
    output logic                   done
);

    typedef logic [DEPTH-1:0][WIDTH-1:0] stages_t;
    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    stages_t          stage_q, stage_d;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dir_q, dir_d;
    logic             rot_q, rot_d;
    logic             done_q, done_d;

    // One-position shift; the vacated end takes the serial input or,
    // when rotating, the stage that just fell off the other end.
    function automatic stages_t shift_f(
        input stages_t          cur,
        input logic             down,
        input logic             r,
        input logic [WIDTH-1:0] lo,
        input logic [WIDTH-1:0] hi
    );
        stages_t nxt;
        nxt = cur;
        if (down) begin
            for (int i = 0; i < DEPTH - 1; i++) nxt[i] = cur[i+1];
            nxt[DEPTH-1] = r ? cur[0] : hi;
        end else begin
            for (int i = 1; i < DEPTH; i++) nxt[i] = cur[i-1];
            nxt[0] = r ? cur[DEPTH-1] : lo;
        end
        return nxt;
    endfunction

    always_comb begin
        stage_d = stage_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        rot_d   = rot_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    dir_d = burst_dir;
                    rot_d = rot;
                    cnt_d = burst_len;
                    if (burst_len == '0) done_d  = 1'b1;
                    else                 state_d = RUN;
                end else if (en) begin
                    unique case (mode)
                        2'b00: ;
                        2'b01: stage_d = shift_f(stage_q, 1'b0, rot, sin_lo, sin_hi);
                        2'b10: stage_d = shift_f(stage_q, 1'b1, rot, sin_lo, sin_hi);
                        2'b11: stage_d = stages_t'(pin);
                    endcase
                end
            end
            RUN: begin
                stage_d = shift_f(stage_q, dir_q, rot_q, sin_lo, sin_hi);
                cnt_d   = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stage_q <= '0;
            state_q <= IDLE;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
            rot_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            stage_q <= stage_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            rot_q   <= rot_d;
            done_q  <= done_d;
        end
    end

    assign pout    = stage_q;
    assign sout_hi = stage_q[DEPTH-1];
    assign sout_lo = stage_q[0];
    assign busy    = (state_q == RUN);
    assign done    = done_q;

endmodule

// File: tb/tb_shift_reg_univ.sv
// Bench for shift_reg_univ: directed table, hand-written burst/reset
// sequences and random traffic against a queue-based reference model.
module tb_shift_reg_univ;

    localparam int WIDTH = 4;
    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PW    = WIDTH * DEPTH;

    logic             clk = 1'b0;
    logic             reset;
    logic             en;
    logic [1:0]       mode;
    logic             rot;
    logic [WIDTH-1:0] sin_lo;
    logic [WIDTH-1:0] sin_hi;
    logic [PW-1:0]    pin;
    logic             start;
    logic             burst_dir;
    logic [CNT_W-1:0] burst_len;
    logic [PW-1:0]    pout;
    logic [WIDTH-1:0] sout_hi;
    logic [WIDTH-1:0] sout_lo;
    logic             busy;
    logic             done;

    shift_reg_univ #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .en(en), .mode(mode), .rot(rot),
        .sin_lo(sin_lo), .sin_hi(sin_hi), .pin(pin), .start(start),
        .burst_dir(burst_dir), .burst_len(burst_len), .pout(pout),
        .sout_hi(sout_hi), .sout_lo(sout_lo), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: q[0] is stage 0; a pending-shift count stands in
    // for the burst controller.
    int q[$];
    int rem;
    bit mdir, mrot, mdone;

    typedef struct {
        bit         en;
        bit [1:0]   mode;
        bit         rot;
        bit [3:0]   sin_lo;
        bit [3:0]   sin_hi;
        bit [15:0]  pin;
        bit [15:0]  exp_pout;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [PW-1:0] mpack();
        logic [PW-1:0] v;
        v = '0;
        for (int i = 0; i < DEPTH; i++) v[i*WIDTH +: WIDTH] = WIDTH'(q[i]);
        return v;
    endfunction

    task automatic model_reset();
        q = {};
        for (int i = 0; i < DEPTH; i++) q.push_back(0);
        rem = 0;
        mdone = 0;
    endtask

    task automatic model_shift(input bit down, input bit r);
        int f;
        if (!down) begin
            f = r ? q[DEPTH-1] : int'(sin_lo);
            void'(q.pop_back());
            q.push_front(f);
        end else begin
            f = r ? q[0] : int'(sin_hi);
            void'(q.pop_front());
            q.push_back(f);
        end
    endtask

    task automatic model_cycle();
        mdone = 0;
        if (rem > 0) begin
            model_shift(mdir, mrot);
            rem--;
            if (rem == 0) mdone = 1;
        end else if (start) begin
            mdir = burst_dir;
            mrot = rot;
            rem  = int'(burst_len);
            if (rem == 0) mdone = 1;
        end else if (en) begin
            case (mode)
                2'b01: model_shift(1'b0, rot);
                2'b10: model_shift(1'b1, rot);
                2'b11: for (int i = 0; i < DEPTH; i++)
                           q[i] = int'(pin[i*WIDTH +: WIDTH]);
                default: ;
            endcase
        end
    endtask

    task automatic compare_all(input string tag);
        logic [PW-1:0] m;
        m = mpack();
        check({tag, ".pout"},    64'(pout),    64'(m));
        check({tag, ".sout_hi"}, 64'(sout_hi), 64'(m[PW-1 -: WIDTH]));
        check({tag, ".sout_lo"}, 64'(sout_lo), 64'(m[WIDTH-1:0]));
        check({tag, ".busy"},    64'(busy),    64'(rem > 0));
        check({tag, ".done"},    64'(done),    64'(mdone));
    endtask

    task automatic step(input string tag);
        model_cycle();
        @(posedge clk);
        #1;
        compare_all(tag);
    endtask

    task automatic idle_inputs();
        en = 0; mode = 0; rot = 0; sin_lo = 0; sin_hi = 0; pin = 0;
        start = 0; burst_dir = 0; burst_len = 0;
    endtask

    vec_t tbl[11];

    initial begin
        tbl[0]  = '{1, 2'b11, 0, 4'h0, 4'h0, 16'h4321, 16'h4321};
        tbl[1]  = '{1, 2'b01, 0, 4'hE, 4'h0, 16'h0000, 16'h321E};
        tbl[2]  = '{1, 2'b01, 0, 4'hE, 4'h0, 16'h0000, 16'h21EE};
        tbl[3]  = '{1, 2'b11, 1, 4'h0, 4'h0, 16'h4321, 16'h4321};
        tbl[4]  = '{1, 2'b10, 1, 4'h0, 4'h7, 16'h0000, 16'h1432};
        tbl[5]  = '{0, 2'b01, 0, 4'h5, 4'h0, 16'h0000, 16'h1432};
        tbl[6]  = '{0, 2'b01, 0, 4'h5, 4'h0, 16'h0000, 16'h1432};
        tbl[7]  = '{0, 2'b01, 0, 4'h5, 4'h0, 16'h0000, 16'h1432};
        tbl[8]  = '{1, 2'b00, 0, 4'h5, 4'h0, 16'hFFFF, 16'h1432};
        tbl[9]  = '{1, 2'b01, 1, 4'h0, 4'h0, 16'h0000, 16'h4321};
        tbl[10] = '{1, 2'b10, 0, 4'h0, 4'h9, 16'h0000, 16'h9432};

        idle_inputs();
        reset = 0;
        model_reset();
        #12;
        compare_all("reset");
        reset = 1;

        foreach (tbl[i]) begin
            en = tbl[i].en; mode = tbl[i].mode; rot = tbl[i].rot;
            sin_lo = tbl[i].sin_lo; sin_hi = tbl[i].sin_hi; pin = tbl[i].pin;
            step($sformatf("tbl%0d", i));
            check($sformatf("tbl%0d.exp", i), 64'(pout), 64'(tbl[i].exp_pout));
        end

        // asynchronous reset mid-cycle after loading ABCD
        idle_inputs();
        en = 1; mode = 2'b11; pin = 16'hABCD;
        step("load_abcd");
        idle_inputs();
        #2;
        reset = 0;
        #1;
        model_reset();
        check("async.pout", 64'(pout), 64'h0);
        check("async.busy", 64'(busy), 64'h0);
        check("async.done", 64'(done), 64'h0);
        reset = 1;

        // burst of 3 up shifts, start pulsed mid-burst
        en = 1; mode = 2'b11; pin = 16'h0000;
        step("b3.load");
        idle_inputs();
        en = 1; mode = 2'b11; pin = 16'hFFFF;
        start = 1; burst_dir = 0; burst_len = 3;
        step("b3.start");
        check("b3.start.hold", 64'(pout), 64'h0);
        start = 0; sin_lo = 4'h1;
        step("b3.s1");
        start = 1; burst_len = 1; burst_dir = 1; sin_lo = 4'h2;
        step("b3.s2");
        start = 0; sin_lo = 4'h3;
        step("b3.s3");
        check("b3.final", 64'(pout), 64'h0123);
        check("b3.done", 64'(done), 64'h1);
        check("b3.busy", 64'(busy), 64'h0);
        start = 1; burst_dir = 1; burst_len = 1; sin_hi = 4'hF;
        step("b3.restart");
        check("b3.restart.busy", 64'(busy), 64'h1);
        start = 0;
        step("b3.restart.shift");
        check("b3.restart.pout", 64'(pout), 64'hF012);

        // zero-length burst
        idle_inputs();
        start = 1; burst_len = 0;
        step("b0.start");
        check("b0.done", 64'(done), 64'h1);
        check("b0.busy", 64'(busy), 64'h0);
        check("b0.pout", 64'(pout), 64'hF012);
        start = 0;
        step("b0.after");

        // 5 rotating down shifts on 4321, rot changed mid-burst
        en = 1; mode = 2'b11; pin = 16'h4321;
        step("b5.load");
        idle_inputs();
        start = 1; burst_dir = 1; rot = 1; burst_len = 5; sin_hi = 4'hA;
        step("b5.start");
        start = 0; rot = 0;
        for (int i = 0; i < 5; i++) step($sformatf("b5.s%0d", i));
        check("b5.final", 64'(pout), 64'h1432);
        check("b5.done", 64'(done), 64'h1);

        // reset during a burst
        idle_inputs();
        start = 1; burst_len = 3; sin_lo = 4'h6;
        step("br.start");
        start = 0;
        step("br.s1");
        #2;
        reset = 0;
        #1;
        model_reset();
        check("br.busy", 64'(busy), 64'h0);
        check("br.done", 64'(done), 64'h0);
        check("br.pout", 64'(pout), 64'h0);
        reset = 1;
        for (int i = 0; i < 4; i++) step($sformatf("br.after%0d", i));

        // random traffic against the model
        for (int n = 0; n < 600; n++) begin
            en        = 1'($urandom);
            mode      = 2'($urandom);
            rot       = 1'($urandom);
            sin_lo    = WIDTH'($urandom);
            sin_hi    = WIDTH'($urandom);
            pin       = PW'($urandom);
            start     = ($urandom_range(0, 7) == 0);
            burst_dir = 1'($urandom);
            burst_len = CNT_W'($urandom_range(0, 7));
            if ($urandom_range(0, 99) == 0) begin
                reset = 0;
                #1;
                model_reset();
                compare_all("rnd.reset");
                reset = 1;
            end
            step("rnd");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/shift_reg_univ.md
Name: shift_reg_univ

Overview:
- Parametrised universal shift register: DEPTH stages, each WIDTH bits wide.
- Per-cycle modes: hold, shift up, shift down, parallel load.
- Optional rotate instead of serial fill.
- A burst controller performs N back-to-back shifts from a single start pulse.
- Successor to the single-bit, fixed-4, left-shift-only serial register. Used as a serialiser/deserialiser and delay line between datapath blocks.

Parameters:
- WIDTH, 4, bits per stage (lane width); >=1
- DEPTH, 4, number of stages; >=2
- CNT_W, $clog2(DEPTH+1), width of burst_len and the internal burst counter

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- en  in  1  enables mode operation when the burst FSM is IDLE
- mode  in  2  00 hold, 01 shift up, 10 shift down, 11 parallel load
- rot  in  1  1 = rotate: the outgoing stage refills the vacated end, serial input ignored
- sin_lo  in  WIDTH  serial input into stage 0 on shift up
- sin_hi  in  WIDTH  serial input into stage DEPTH-1 on shift down
- pin  in  DEPTH*WIDTH  parallel load data; stage i = pin[i*WIDTH +: WIDTH]
- start  in  1  burst request, sampled only in IDLE
- burst_dir  in  1  burst direction: 0 up, 1 down; sampled with start
- burst_len  in  CNT_W  number of burst shifts; sampled with start
- pout  out  DEPTH*WIDTH  all stages, same packing as pin
- sout_hi  out  WIDTH  stage DEPTH-1
- sout_lo  out  WIDTH  stage 0
- busy  out  1  burst FSM is in RUN
- done  out  1  one-cycle pulse at burst completion

Behaviour:
- All state is registered; outputs are direct register values and carry no combinational path from inputs.
- Reset (reset=0, asynchronous): all stages 0, FSM IDLE, counter 0, busy=0, done=0. This takes effect immediately, including mid-burst; a burst in progress is abandoned.
- Shift up: stage[i] <= stage[i-1] for i>=1. stage[0] <= rot ? stage[DEPTH-1] : sin_lo.
- Shift down: stage[i] <= stage[i+1] for i<DEPTH-1. stage[DEPTH-1] <= rot ? stage[0] : sin_hi.
- Parallel load: all stages <= pin in one cycle. rot is ignored.
- Hold, or en=0 in IDLE: all stages keep their value.
- FSM IDLE:
  - start=0: execute mode if en=1.
  - start=1: the start cycle executes no mode operation (the register holds). Latch burst_dir, rot and burst_len.
  - If burst_len=0: stay IDLE and assert done the next cycle; no shift occurs.
  - Otherwise: go to RUN with counter=burst_len.
- FSM RUN:
  - busy=1. Each cycle, shift one position in the latched direction using the latched rot and the live sin_lo/sin_hi.
  - Decrement the counter each cycle.
  - en, mode, start and pin are ignored.
  - When the counter reaches 1, the final shift occurs, the FSM goes to IDLE, and done=1 for exactly that following cycle with busy=0.
- Latency: start sampled at edge k. Shifts occur at edges k+1 .. k+N. busy is high after k through k+N. done is high between edges k+N and k+N+1.
- burst_len > DEPTH is legal: shifting continues for the full count, and in fill mode the register ends holding only the most recent serial inputs.
- start while busy=1 is ignored and not queued. start in the done cycle is accepted, because the FSM is already IDLE.
- Every shift drops the outgoing stage (non-rotate) or recirculates it (rotate); there is no overflow flag.

Test Plan:
- Reset/async: load pin=16'hABCD, then drop reset mid-cycle -> pout=0 immediately, without waiting for a clock edge; busy=0, done=0.
- Parallel load + shift up: load 16'h4321, en=1, mode=01, sin_lo=4'hE for 2 cycles -> pout=16'h21EE, sout_hi=4'h2.
- Shift down with rotate: load 16'h4321, mode=10, rot=1, 1 cycle -> pout=16'h1432, sout_lo=4'h2.
- Hold/en: en=0 with mode=01 for 3 cycles -> pout unchanged; then mode=00, en=1 -> pout unchanged.
- Burst: load 16'h0000, start with burst_dir=0, burst_len=3, sin_lo=4'h1,2,3 on successive cycles -> busy high 3 cycles, then pout=16'h0123 and a one-cycle done; start pulsed mid-burst is ignored.
- Edge cases:
  - burst_len=0 -> no shift, done one cycle later, busy never high.
  - burst_len=5 with rot=1 on 16'h4321 -> pout=16'h1432.
  - reset asserted mid-burst -> busy=0 immediately and no done pulse.
